// File: rtl/etc_pkg.sv
// rtl/etc_pkg.sv - shared types and constants for the extended-tensor-core tile feeder
package etc_pkg;

    localparam int W_DEFAULT    = 16;
    // Cycles from the core sampling A/B until its result is valid.
    localparam int CORE_LATENCY = 2;

    typedef logic [3:0][W_DEFAULT-1:0]      row_t;
    typedef logic [3:0][3:0][W_DEFAULT-1:0] tile_t;

    // Op tag encoding: zero is a plain multiply-accumulate, anything else is min-mul.
    localparam logic [1:0] OP_MMA = 2'd0;

    function automatic logic is_minmul(input logic [1:0] op);
        return op != OP_MMA;
    endfunction

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/etc_credit_counter.sv
// rtl/etc_credit_counter.sv - downstream result-buffer credit counter
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   issue       - a tile pair is issued this cycle (consumes one slot)
//   credit_ret  - downstream freed one slot this cycle
//   count       - current credit count, resets to CREDITS
//   nonzero     - count != 0
//   err         - sticky: a credit came back while already full
module etc_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue,
    input  logic       credit_ret,
    output logic [3:0] count,
    output logic       nonzero,
    output logic       err
);

    localparam logic [3:0] MAX_CREDITS = 4'(CREDITS);

    logic [3:0] r_count;
    logic       r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= MAX_CREDITS;
            r_err   <= 1'b0;
        end else begin
            // Issue plus return in the same cycle cancel out.
            if (issue && !credit_ret) begin
                r_count <= r_count - 4'd1;
            end else if (credit_ret && !issue) begin
                if (r_count == MAX_CREDITS) begin
                    r_err <= 1'b1;
                end else begin
                    r_count <= r_count + 4'd1;
                end
            end
        end
    end

    assign count   = r_count;
    assign nonzero = (r_count != 4'd0);
    assign err     = r_err;

endmodule

// File: rtl/etc_tile_feeder.sv
// rtl/etc_tile_feeder.sv - assembles 4x4 A/B tiles from a row stream and issues them to the core
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - row beat handshake; 4 A rows then 4 B rows per tile pair
//   in_row, in_op         - row data (element [j] = column j); op tag taken on beat 0
//   core_inA/core_inB     - tiles to the core; live buffer during ISSUE, held copy otherwise
//   core_op               - op to the core, updated at the end of the ISSUE cycle
//   res_valid/res_op      - core result valid (issue cycle + CORE_LATENCY) and its tag
//   credit_ret            - downstream freed one result slot
//   credits, err_credit   - credit count and sticky over-return flag
module etc_tile_feeder
    import etc_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int CREDITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0][W-1:0]      in_row,
    input  logic [1:0]             in_op,
    output logic [3:0][3:0][W-1:0] core_inA,
    output logic [3:0][3:0][W-1:0] core_inB,
    output logic [1:0]             core_op,
    output logic                   res_valid,
    output logic [1:0]             res_op,
    input  logic                   credit_ret,
    output logic [3:0]             credits,
    output logic                   err_credit
);

    feeder_state_e r_state;
    feeder_state_e w_state_nxt;

    logic [2:0]             r_beat;
    logic [1:0]             r_op_buf;
    logic [3:0][3:0][W-1:0] r_buf_a;
    logic [3:0][3:0][W-1:0] r_buf_b;
    logic [3:0][3:0][W-1:0] r_held_a;
    logic [3:0][3:0][W-1:0] r_held_b;
    logic [1:0]             r_core_op;

    logic [CORE_LATENCY-1:0]       r_res_v;
    logic [CORE_LATENCY-1:0][1:0]  r_res_op;

    logic w_accept;
    logic w_last_beat;
    logic w_issue;
    logic w_fill_ready;
    logic w_cred_nonzero;

    assign w_accept    = in_valid && in_ready;
    assign w_last_beat = w_accept && (r_beat == 3'd7);
    assign w_issue     = (r_state == ISSUE);

    // Gated by rst_n so the handshake is closed while reset is held,
    // even though the state register already sits in FILL.
    assign in_ready = rst_n && w_fill_ready;

    etc_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (w_issue),
        .credit_ret (credit_ret),
        .count      (credits),
        .nonzero    (w_cred_nonzero),
        .err        (err_credit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A credit returned this cycle counts as available for the issue decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_fill_ready = 1'b0;
        case (r_state)
            FILL: begin
                w_fill_ready = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = (w_cred_nonzero || credit_ret) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                if (w_cred_nonzero || credit_ret) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = FILL;
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat   <= 3'd0;
            r_op_buf <= 2'd0;
            r_buf_a  <= '0;
            r_buf_b  <= '0;
        end else if (w_accept) begin
            if (!r_beat[2]) begin
                r_buf_a[r_beat[1:0]] <= in_row;
            end else begin
                r_buf_b[r_beat[1:0]] <= in_row;
            end
            if (r_beat == 3'd0) begin
                r_op_buf <= in_op;
            end
            r_beat <= r_beat + 3'd1;
        end
    end

    // The assembly buffer cannot change during ISSUE (in_ready is low), so
    // capturing it at the closing edge gives the same value the core saw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held_a  <= '0;
            r_held_b  <= '0;
            r_core_op <= 2'd0;
        end else if (w_issue) begin
            r_held_a  <= r_buf_a;
            r_held_b  <= r_buf_b;
            r_core_op <= r_op_buf;
        end
    end

    assign core_inA = w_issue ? r_buf_a : r_held_a;
    assign core_inB = w_issue ? r_buf_b : r_held_b;
    assign core_op  = r_core_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_v  <= '0;
            r_res_op <= '0;
        end else begin
            r_res_v  <= {r_res_v[CORE_LATENCY-2:0], w_issue};
            r_res_op <= {r_res_op[CORE_LATENCY-2:0], r_op_buf};
        end
    end

    assign res_valid = r_res_v[CORE_LATENCY-1];
    assign res_op    = r_res_op[CORE_LATENCY-1];

endmodule

// File: tb/tb_etc_tile_feeder.sv
// tb/tb_etc_tile_feeder.sv - directed self-checking bench for etc_tile_feeder
module tb_etc_tile_feeder;
    import etc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    row_t       in_row;
    logic [1:0] in_op;
    tile_t      core_inA;
    tile_t      core_inB;
    logic [1:0] core_op;
    logic       res_valid;
    logic [1:0] res_op;
    logic       credit_ret;
    logic [3:0] credits;
    logic       err_credit;

    int n_checks;
    int n_errors;

    int         exp_cred;
    logic [1:0] exp_op;

    etc_tile_feeder #(
        .W       (W_DEFAULT),
        .CREDITS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .in_op      (in_op),
        .core_inA   (core_inA),
        .core_inB   (core_inB),
        .core_op    (core_op),
        .res_valid  (res_valid),
        .res_op     (res_op),
        .credit_ret (credit_ret),
        .credits    (credits),
        .err_credit (err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic tile_t mk_tile(input int base);
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = 16'(base + r * 4 + c);
        return t;
    endfunction

    function automatic tile_t mk_identity();
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = (r == c) ? 16'd1 : 16'd0;
        return t;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) check("ready_timeout", 256'(in_ready), 256'(1));
    endtask

    // Presents nbeats beats; op on beat 0, a different tag on later beats
    // to show those are ignored. With gaps, an idle garbage cycle precedes each beat.
    task automatic send_tile(input tile_t a, input tile_t b, input logic [1:0] op,
                             input bit gaps, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                in_row   = '1;
                in_op    = 2'd3;
                step();
            end
            in_valid = 1'b1;
            in_row   = (k < 4) ? a[k] : b[k - 4];
            in_op    = (k == 0) ? op : ~op;
            wait_ready();
            step();
        end
        in_valid = 1'b0;
        in_op    = 2'd0;
    endtask

    // Called in the ISSUE cycle; follows the pair through core_op and res_valid.
    task automatic expect_issue(input string tag, input tile_t a, input tile_t b,
                                input logic [1:0] op, input bit ret);
        check({tag, "_rdy"},    256'(in_ready), 256'(0));
        check({tag, "_A"},      256'(core_inA), 256'(a));
        check({tag, "_B"},      256'(core_inB), 256'(b));
        check({tag, "_ophold"}, 256'(core_op),  256'(exp_op));
        check({tag, "_cred0"},  256'(credits),  256'(exp_cred));
        credit_ret = ret;
        step();
        credit_ret = 1'b0;
        if (!ret) exp_cred--;
        exp_op = op;
        check({tag, "_op"},     256'(core_op),   256'(exp_op));
        check({tag, "_cred1"},  256'(credits),   256'(exp_cred));
        check({tag, "_rv1"},    256'(res_valid), 256'(0));
        step();
        check({tag, "_rv2"},    256'(res_valid), 256'(1));
        check({tag, "_rop"},    256'(res_op),    256'(op));
        step();
        check({tag, "_rv3"},    256'(res_valid), 256'(0));
        check({tag, "_heldA"},  256'(core_inA),  256'(a));
        check({tag, "_heldB"},  256'(core_inB),  256'(b));
        check({tag, "_rdy2"},   256'(in_ready),  256'(1));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        credit_ret = 1'b0;
        in_op      = 2'd0;
        in_row     = '0;
        step();
        check("rst_rdy",  256'(in_ready),   256'(0));
        check("rst_cred", 256'(credits),    256'(4));
        check("rst_err",  256'(err_credit), 256'(0));
        check("rst_rv",   256'(res_valid),  256'(0));
        check("rst_op",   256'(core_op),    256'(0));
        check("rst_A",    256'(core_inA),   256'(0));
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", 256'(in_ready), 256'(1));
        exp_cred = 4;
        exp_op   = 2'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        tile_t ta, tb, tc, td;
        n_checks = 0;
        n_errors = 0;
        do_reset();

        // Basic issue: A = identity, B rows {1,2,3,4}..{13,14,15,16}, op 0.
        ta = mk_identity();
        tb = mk_tile(1);
        send_tile(ta, tb, 2'd0, 1'b0, 8);
        expect_issue("basic", ta, tb, 2'd0, 1'b0);

        // Op capture: tag 1 on beat 0 only.
        tc = mk_tile(100);
        td = mk_tile(200);
        send_tile(tc, td, 2'd1, 1'b0, 8);
        expect_issue("opcap", tc, td, 2'd1, 1'b0);

        // Credit return in the ISSUE cycle at credits=2 leaves it at 2.
        ta = mk_tile(300);
        tb = mk_tile(400);
        send_tile(ta, tb, 2'd2, 1'b0, 8);
        expect_issue("simul", ta, tb, 2'd2, 1'b1);

        // Backpressure gaps: only accepted beats land in the tile.
        tc = mk_tile(500);
        td = mk_tile(600);
        send_tile(tc, td, 2'd3, 1'b1, 8);
        expect_issue("gaps", tc, td, 2'd3, 1'b0);

        // Over-return: 1 -> 4, then one more flags err_credit.
        for (int i = 0; i < 3; i++) begin
            credit_ret = 1'b1;
            step();
        end
        credit_ret = 1'b0;
        check("ret_cred4", 256'(credits),    256'(4));
        check("ret_err0",  256'(err_credit), 256'(0));
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        check("over_cred", 256'(credits),    256'(4));
        check("over_err",  256'(err_credit), 256'(1));
        step();
        step();
        check("err_sticky", 256'(err_credit), 256'(1));

        // Reset after beat 5 of a tile; then a fresh tile must fill from row 0.
        send_tile(mk_tile(700), mk_tile(800), 2'd1, 1'b0, 5);
        do_reset();
        ta = mk_tile(900);
        tb = mk_tile(1000);
        send_tile(ta, tb, 2'd0, 1'b0, 8);
        expect_issue("rst_mid", ta, tb, 2'd0, 1'b0);

        // Reset one cycle after ISSUE: the in-flight result must vanish.
        send_tile(mk_tile(1100), mk_tile(1200), 2'd1, 1'b0, 8);
        check("pre_rst_issue_A", 256'(core_inA), 256'(mk_tile(1100)));
        step();
        do_reset();
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (res_valid) seen++;
                step();
            end
            check("no_rv_after_rst", 256'(seen), 256'(0));
        end

        // Credit exhaustion: 4 issues, the 5th pair parks in WAIT.
        for (int i = 0; i < 4; i++) begin
            ta = mk_tile(2000 + i * 64);
            tb = mk_tile(2032 + i * 64);
            send_tile(ta, tb, 2'(i), 1'b0, 8);
            expect_issue("exh", ta, tb, 2'(i), 1'b0);
        end
        check("exh_cred0", 256'(credits), 256'(0));
        tc = mk_tile(3000);
        td = mk_tile(3100);
        send_tile(tc, td, 2'd1, 1'b0, 8);
        for (int i = 0; i < 3; i++) begin
            check("wait_rdy",  256'(in_ready),  256'(0));
            check("wait_held", 256'(core_inA),  256'(ta));
            check("wait_rv",   256'(res_valid), 256'(0));
            step();
        end
        credit_ret = 1'b1;
        step();
        credit_ret = 1'b0;
        exp_cred = 1;
        expect_issue("wake", tc, td, 2'd1, 1'b0);
        check("final_cred", 256'(credits), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
